axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder (slave end of the team's AXI4-Lite bus) that exposes a bank of read/write control registers and read-only status words to a CPU/PS master. It drives control outputs into the 3DNR datapath and samples its status inputs. Write and read channels are independent, with one outstanding transaction per direction.

---
 rtl/axi_lite_reg_slave_if.sv | 34 +++
 rtl/axi_lite_reg_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a CPU-side master and a register-bank responder.
// Write (AW/W/B) and read (AR/R) channels are independent.
interface axi_lite_reg_slave_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 12
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NREG RW control words followed by NSTAT RO status words.
// One outstanding transaction per direction; AW and W may arrive in either order.
module axi_lite_reg_slave #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 12,
   parameter int unsigned NREG  = 8,
   parameter int unsigned NSTAT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   axi_lite_reg_slave_if.slave   bus,
   output logic [NREG*DW-1:0]    ctrl_o,
   input  logic [NSTAT*DW-1:0]   stat_i,
   output logic [NREG-1:0]       wr_pulse_o
);
   localparam int unsigned SW = DW / 8;
   localparam int unsigned LB = $clog2(SW);
   localparam int unsigned IW = AW - LB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_HOLD_AW, W_HOLD_W, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic                       live;
   logic [IW-1:0]              aw_idx_q;
   logic [DW-1:0]              wdata_q;
   logic [SW-1:0]              wstrb_q;
   logic [NREG-1:0][DW-1:0]    ctrl_q;
   logic [1:0]                 bresp_q;
   logic [DW-1:0]              rdata_q;
   logic [1:0]                 rresp_q;

   logic                       aw_hs, w_hs, ar_hs, commit;
   logic [IW-1:0]              c_idx;
   logic [DW-1:0]              c_data;
   logic [SW-1:0]              c_strb;
   logic [1:0]                 c_resp;
   logic [IW-1:0]              r_idx;
   logic [DW-1:0]              r_data;
   logic [1:0]                 r_resp;

   logic                       unused_addr_bits;
   assign unused_addr_bits = ^{bus.awaddr[LB-1:0], bus.araddr[LB-1:0]};

   // Keeps every ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) live <= 1'b0;
      else       live <= 1'b1;
   end

   assign bus.awready = live && (wr_state == W_IDLE || wr_state == W_HOLD_W);
   assign bus.wready  = live && (wr_state == W_IDLE || wr_state == W_HOLD_AW);
   assign bus.bvalid  = (wr_state == W_RESP);
   assign bus.bresp   = bresp_q;
   assign bus.arready = live && (rd_state == R_IDLE);
   assign bus.rvalid  = (rd_state == R_RESP);
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign ctrl_o      = ctrl_q;

   assign aw_hs = bus.awvalid && bus.awready;
   assign w_hs  = bus.wvalid  && bus.wready;
   assign ar_hs = bus.arvalid && bus.arready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   always_comb begin
      wr_next = wr_state;
      commit  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) commit  = 1'b1;
            else if (aw_hs)    wr_next = W_HOLD_AW;
            else if (w_hs)     wr_next = W_HOLD_W;
         end
         W_HOLD_AW: if (w_hs)       commit  = 1'b1;
         W_HOLD_W:  if (aw_hs)      commit  = 1'b1;
         W_RESP:    if (bus.bready) wr_next = W_IDLE;
         default:                   wr_next = W_IDLE;
      endcase
      if (commit) wr_next = W_RESP;
   end

   // The second handshake's live bus values bypass the holding registers.
   always_comb begin
      c_idx  = aw_hs ? bus.awaddr[AW-1:LB] : aw_idx_q;
      c_data = w_hs  ? bus.wdata : wdata_q;
      c_strb = w_hs  ? bus.wstrb : wstrb_q;
      if (32'(c_idx) < NREG)              c_resp = RESP_OKAY;
      else if (32'(c_idx) < NREG + NSTAT) c_resp = RESP_SLVERR;
      else                                c_resp = RESP_DECERR;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         ctrl_q     <= '0;
         bresp_q    <= '0;
         wr_pulse_o <= '0;
      end else begin
         wr_pulse_o <= '0;
         if (aw_hs) aw_idx_q <= bus.awaddr[AW-1:LB];
         if (w_hs) begin
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
         end
         if (commit) begin
            bresp_q <= c_resp;
            for (int unsigned k = 0; k < NREG; k++) begin
               if (c_resp == RESP_OKAY && 32'(c_idx) == k) begin
                  wr_pulse_o[k] <= 1'b1;
                  for (int unsigned b = 0; b < SW; b++) begin
                     if (c_strb[b]) ctrl_q[k][b*8 +: 8] <= c_data[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs)      rd_next = R_RESP;
         R_RESP:  if (bus.rready) rd_next = R_IDLE;
         default:                 rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      r_idx  = bus.araddr[AW-1:LB];
      r_data = '0;
      r_resp = RESP_DECERR;
      for (int unsigned k = 0; k < NREG; k++) begin
         if (32'(r_idx) == k) begin
            r_data = ctrl_q[k];
            r_resp = RESP_OKAY;
         end
      end
      for (int unsigned k = 0; k < NSTAT; k++) begin
         if (32'(r_idx) == NREG + k) begin
            r_data = stat_i[k*DW +: DW];
            r_resp = RESP_OKAY;
         end
      end
   end

   // ctrl_q is read before any same-edge commit lands, so reads see the old value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= '0;
         rresp_q <= '0;
      end else if (ar_hs) begin
         rdata_q <= r_data;
         rresp_q <= r_resp;
      end
   end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed vector table, multi-cycle corner sequences,
// and random traffic checked against an array-based register map model.
module tb_axi_lite_reg_slave;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;
   localparam int unsigned NREG = 8;
   localparam int unsigned NSTAT = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [NREG*DW-1:0]  ctrl_o;
   logic [NSTAT*DW-1:0] stat_i;
   logic [NREG-1:0]     wr_pulse_o;

   always #5 clk = ~clk;

   axi_lite_reg_slave_if #(.DW(DW), .AW(AW)) bus ();

   axi_lite_reg_slave #(.DW(DW), .AW(AW), .NREG(NREG), .NSTAT(NSTAT)) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus),
      .ctrl_o(ctrl_o),
      .stat_i(stat_i),
      .wr_pulse_o(wr_pulse_o)
   );

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] m_ctrl [NREG];
   logic [31:0] m_stat [NSTAT];

   always_comb begin
      for (int k = 0; k < int'(NSTAT); k++) stat_i[k*32 +: 32] = m_stat[k];
   end

   typedef struct {
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      logic [7:0]  exp_pulse;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Register map model: word index = byte address / 4.
   task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp, output logic [7:0] pulse);
      int idx;
      idx = int'(a >> 2);
      pulse = 8'h00;
      if (idx < int'(NREG)) begin
         resp = 2'b00;
         pulse = 8'(1 << idx);
         for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[idx][b*8 +: 8] = d[b*8 +: 8];
      end else if (idx < int'(NREG + NSTAT)) begin
         resp = 2'b10;
      end else begin
         resp = 2'b11;
      end
   endtask

   task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
      int idx;
      idx = int'(a >> 2);
      if (idx < int'(NREG)) begin
         d = m_ctrl[idx]; resp = 2'b00;
      end else if (idx < int'(NREG + NSTAT)) begin
         d = m_stat[idx - int'(NREG)]; resp = 2'b00;
      end else begin
         d = 32'h0; resp = 2'b11;
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] r;
      for (int k = 0; k < int'(NREG); k++) r[k*32 +: 32] = m_ctrl[k];
      return r;
   endfunction

   // lead > 0 delays W behind AW; lead < 0 delays AW behind W.
   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly,
                           input logic [1:0] exp_resp, input logic [7:0] exp_pulse, input string tag);
      int nb;
      fork
         begin
            int na;
            na = 0;
            if (lead < 0) repeat (-lead) step();
            bus.awaddr = a;
            bus.awvalid = 1'b1;
            while (!bus.awready && na < 64) begin step(); na++; end
            if (na >= 64) check({tag, "_aw_timeout"}, 256'(0), 256'(1));
            step();
            bus.awvalid = 1'b0;
         end
         begin
            int nw;
            nw = 0;
            if (lead > 0) repeat (lead) step();
            bus.wdata = d;
            bus.wstrb = s;
            bus.wvalid = 1'b1;
            while (!bus.wready && nw < 64) begin step(); nw++; end
            if (nw >= 64) check({tag, "_w_timeout"}, 256'(0), 256'(1));
            step();
            bus.wvalid = 1'b0;
         end
      join
      nb = 0;
      while (!bus.bvalid && nb < 64) begin step(); nb++; end
      check({tag, "_bvalid_at_commit"}, 256'(nb), 256'(0));
      check({tag, "_bresp"}, 256'(bus.bresp), 256'(exp_resp));
      check({tag, "_wr_pulse"}, 256'(wr_pulse_o), 256'(exp_pulse));
      repeat (bdly) begin
         step();
         check({tag, "_b_hold"}, 256'({bus.bvalid, bus.bresp, bus.awready, bus.wready}),
               256'({1'b1, exp_resp, 2'b00}));
         check({tag, "_pulse_one_cycle"}, 256'(wr_pulse_o), 256'(0));
      end
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check({tag, "_b_done"}, 256'({bus.bvalid, wr_pulse_o}), 256'(0));
   endtask

   task automatic do_read(input logic [11:0] a, input int rdly,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
      int n;
      n = 0;
      bus.araddr = a;
      bus.arvalid = 1'b1;
      while (!bus.arready && n < 64) begin step(); n++; end
      if (n >= 64) check({tag, "_ar_timeout"}, 256'(0), 256'(1));
      step();
      bus.arvalid = 1'b0;
      check({tag, "_rvalid_latency"}, 256'(bus.rvalid), 256'(1));
      check({tag, "_rdata"}, 256'({bus.rdata, bus.rresp}), 256'({exp_data, exp_resp}));
      repeat (rdly) begin
         step();
         check({tag, "_r_hold"}, 256'({bus.rvalid, bus.arready, bus.rdata, bus.rresp}),
               256'({1'b1, 1'b0, exp_data, exp_resp}));
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      check({tag, "_r_done"}, 256'(bus.rvalid), 256'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  er;
      logic [7:0]  ep;
      logic [31:0] ed;
      logic [11:0] a;

      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      for (int k = 0; k < int'(NREG); k++) m_ctrl[k] = 32'h0;
      m_stat[0] = 32'h11110000;
      m_stat[1] = 32'hCAFEF00D;
      m_stat[2] = 32'h22220002;
      m_stat[3] = 32'h33330003;

      tbl[0]  = '{1'b1, 12'h004, 32'hAABBCCDD, 4'b0011, 2'b00, 32'h0,        8'h02};
      tbl[1]  = '{1'b0, 12'h004, 32'h0,        4'b0000, 2'b00, 32'h0000CCDD, 8'h00};
      tbl[2]  = '{1'b0, 12'h024, 32'h0,        4'b0000, 2'b00, 32'hCAFEF00D, 8'h00};
      tbl[3]  = '{1'b1, 12'h024, 32'hDEADBEEF, 4'b1111, 2'b10, 32'h0,        8'h00};
      tbl[4]  = '{1'b0, 12'h030, 32'h0,        4'b0000, 2'b11, 32'h0,        8'h00};
      tbl[5]  = '{1'b1, 12'h030, 32'h01234567, 4'b1111, 2'b11, 32'h0,        8'h00};
      tbl[6]  = '{1'b1, 12'h006, 32'h11223344, 4'b1100, 2'b00, 32'h0,        8'h02};
      tbl[7]  = '{1'b0, 12'h007, 32'h0,        4'b0000, 2'b00, 32'h1122CCDD, 8'h00};
      tbl[8]  = '{1'b1, 12'h01C, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'h0,        8'h80};
      tbl[9]  = '{1'b0, 12'h01C, 32'h0,        4'b0000, 2'b00, 32'h0,        8'h00};
      tbl[10] = '{1'b0, 12'hFFC, 32'h0,        4'b0000, 2'b11, 32'h0,        8'h00};

      // Reset state and ready release
      #1;
      check("reset_outputs", 256'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
            bus.bresp, bus.rresp, bus.rdata, wr_pulse_o}), 256'(0));
      check("reset_ctrl", ctrl_o, 256'(0));
      repeat (3) step();
      rstn = 1'b1;
      check("ready_before_edge", 256'({bus.awready, bus.wready, bus.arready}), 256'(0));
      step();
      check("ready_after_edge", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));

      // Directed vectors
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].is_wr) begin
            model_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, er, ep);
            do_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, (i % 3) - 1, 0,
                     tbl[i].exp_resp, tbl[i].exp_pulse, $sformatf("vec%0d", i));
         end else begin
            do_read(tbl[i].addr, 0, tbl[i].exp_rdata, tbl[i].exp_resp, $sformatf("vec%0d", i));
         end
         check($sformatf("vec%0d_ctrl", i), ctrl_o, model_flat());
      end

      // AW to idx2 three cycles ahead of W
      model_write(12'h008, 32'h12345678, 4'hF, er, ep);
      bus.awaddr = 12'h008;
      bus.awvalid = 1'b1;
      check("early_aw_ready", 256'(bus.awready), 256'(1));
      step();
      bus.awvalid = 1'b0;
      repeat (3) begin
         check("early_aw_held", 256'({bus.awready, bus.wready, bus.bvalid, wr_pulse_o}),
               256'({1'b0, 1'b1, 1'b0, 8'h00}));
         check("early_aw_reg2_unchanged", 256'(ctrl_o[2*32 +: 32]), 256'(0));
         step();
      end
      bus.wdata = 32'h12345678;
      bus.wstrb = 4'hF;
      bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      check("early_aw_commit", 256'({bus.bvalid, bus.bresp, wr_pulse_o, ctrl_o[2*32 +: 32]}),
            256'({1'b1, 2'b00, 8'h04, 32'h12345678}));
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check("early_aw_done", 256'(bus.bvalid), 256'(0));

      // Write response backpressure
      model_write(12'h00C, 32'h5A5A0001, 4'hF, er, ep);
      do_write(12'h00C, 32'h5A5A0001, 4'hF, 0, 5, er, ep, "bp_write");
      check("bp_write_ctrl", ctrl_o, model_flat());

      // Read backpressure with a concurrent write
      model_read(12'h008, ed, er);
      fork
         do_read(12'h008, 6, ed, er, "bp_read");
         begin
            logic [1:0] wr_r;
            logic [7:0] wp_r;
            model_write(12'h00C, 32'h0BADCAFE, 4'hF, wr_r, wp_r);
            step();
            do_write(12'h00C, 32'h0BADCAFE, 4'hF, 1, 0, wr_r, wp_r, "bp_concurrent_write");
         end
      join
      check("bp_concurrent_ctrl", ctrl_o, model_flat());

      // Reset while an AW is held and a read response is pending
      bus.awaddr = 12'h010;
      bus.awvalid = 1'b1;
      bus.araddr = 12'h004;
      bus.arvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.arvalid = 1'b0;
      check("pre_reset_state", 256'({bus.awready, bus.wready, bus.rvalid}), 256'(3'b011));
      #2;
      rstn = 1'b0;
      #1;
      check("midreset_outputs", 256'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
            bus.bresp, bus.rresp, bus.rdata, wr_pulse_o}), 256'(0));
      check("midreset_ctrl", ctrl_o, 256'(0));
      for (int k = 0; k < int'(NREG); k++) m_ctrl[k] = 32'h0;
      step();
      step();
      rstn = 1'b1;
      step();
      check("post_reset_clean", 256'({bus.bvalid, bus.rvalid, bus.awready, bus.wready}),
            256'(4'b0011));
      model_write(12'h014, 32'hFEEDFACE, 4'hF, er, ep);
      do_write(12'h014, 32'hFEEDFACE, 4'hF, 0, 0, er, ep, "post_reset_write");
      check("post_reset_ctrl", ctrl_o, model_flat());
      model_read(12'h014, ed, er);
      do_read(12'h014, 0, ed, er, "post_reset_read");

      // Random traffic against the model
      for (int i = 0; i < 150; i++) begin
         if (i % 10 == 0) for (int k = 0; k < int'(NSTAT); k++) m_stat[k] = $urandom;
         a = 12'($urandom_range(0, 13) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = 12'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = $urandom;
            s = 4'($urandom);
            model_write(a, d, s, er, ep);
            do_write(a, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)),
                     er, ep, $sformatf("rnd%0d_wr", i));
            check($sformatf("rnd%0d_ctrl", i), ctrl_o, model_flat());
         end else begin
            model_read(a, ed, er);
            do_read(a, int'($urandom_range(0, 2)), ed, er, $sformatf("rnd%0d_rd", i));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
